// File: rtl/seg7_frame_decoder.sv
// Recovers a two-digit hex value from a pair of active-low seven-segment buses.
// A value is accepted only after STABLE_TICKS consecutive identical legal samples.
module seg7_frame_decoder #(
  parameter int unsigned STABLE_TICKS = 3
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       tick,
  input  logic [6:0] HEX0_IN,
  input  logic [6:0] HEX1_IN,
  input  logic       clear_error,
  output logic [7:0] value,
  output logic [1:0] blank,
  output logic       valid,
  output logic       changed,
  output logic       seg_error,
  output logic [1:0] state
);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [3:0] STABLE_C  = 4'(STABLE_TICKS);

  // Returns {legal, blank, nibble}; illegal patterns decode to all zeros.
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   seg_decode = 6'b10_0000;
      7'h79:   seg_decode = 6'b10_0001;
      7'h24:   seg_decode = 6'b10_0010;
      7'h30:   seg_decode = 6'b10_0011;
      7'h19:   seg_decode = 6'b10_0100;
      7'h12:   seg_decode = 6'b10_0101;
      7'h02:   seg_decode = 6'b10_0110;
      7'h78:   seg_decode = 6'b10_0111;
      7'h00:   seg_decode = 6'b10_1000;
      7'h18:   seg_decode = 6'b10_1001;
      7'h08:   seg_decode = 6'b10_1010;
      7'h03:   seg_decode = 6'b10_1011;
      7'h46:   seg_decode = 6'b10_1100;
      7'h21:   seg_decode = 6'b10_1101;
      7'h06:   seg_decode = 6'b10_1110;
      7'h0E:   seg_decode = 6'b10_1111;
      7'h7F:   seg_decode = 6'b11_0000;
      default: seg_decode = 6'b00_0000;
    endcase
  endfunction

  logic [5:0]  dec0_s;
  logic [5:0]  dec1_s;
  logic [13:0] sample_s;
  logic        legal_tick_s;
  logic        illegal_tick_s;
  logic        same_s;
  logic [3:0]  run_next_s;
  logic        accept_s;
  logic [7:0]  new_value_s;
  logic [1:0]  new_blank_s;

  logic [13:0] held_r;
  logic        held_ok_r;
  logic [3:0]  run_r;
  logic [1:0]  state_r;
  logic [1:0]  state_next_s;

  logic [7:0]  value_r;
  logic [1:0]  blank_r;
  logic        valid_r;
  logic        changed_r;
  logic        seg_error_r;
  logic [7:0]  value_next_s;
  logic [1:0]  blank_next_s;
  logic        valid_next_s;
  logic        changed_next_s;
  logic        seg_error_next_s;

  // Sample classification, run-length bookkeeping and acceptance detection.
  always_comb begin
    dec0_s         = seg_decode(HEX0_IN);
    dec1_s         = seg_decode(HEX1_IN);
    sample_s       = {HEX1_IN, HEX0_IN};
    legal_tick_s   = tick & dec0_s[5] & dec1_s[5];
    illegal_tick_s = tick & ~(dec0_s[5] & dec1_s[5]);
    same_s         = held_ok_r & (sample_s == held_r);
    new_value_s    = {dec1_s[3:0], dec0_s[3:0]};
    new_blank_s    = {dec1_s[4], dec0_s[4]};
    if (same_s) begin
      run_next_s = (run_r == 4'd15) ? run_r : run_r + 4'd1;
    end else begin
      run_next_s = 4'd1;
    end
    // A saturated run that already equals the threshold must not re-accept.
    accept_s = legal_tick_s & (run_next_s == STABLE_C) & ~(same_s & (run_r == STABLE_C));
  end

  // Held sample and run counter; an illegal tick invalidates the held sample.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      held_r    <= 14'h0000;
      held_ok_r <= 1'b0;
      run_r     <= 4'd0;
    end else if (legal_tick_s) begin
      held_r    <= sample_s;
      held_ok_r <= 1'b1;
      run_r     <= run_next_s;
    end else if (illegal_tick_s) begin
      held_r    <= 14'h0000;
      held_ok_r <= 1'b0;
      run_r     <= 4'd0;
    end else begin
      held_r    <= held_r;
      held_ok_r <= held_ok_r;
      run_r     <= run_r;
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    if (illegal_tick_s) begin
      state_next_s = (state_r == ST_EMPTY) ? ST_EMPTY : ST_SETTLE;
    end else if (accept_s) begin
      state_next_s = ST_LOCKED;
    end else if (legal_tick_s) begin
      case (state_r)
        ST_EMPTY:  state_next_s = ST_SETTLE;
        ST_SETTLE: state_next_s = ST_SETTLE;
        ST_LOCKED: state_next_s = same_s ? ST_LOCKED : ST_SETTLE;
        default:   state_next_s = ST_EMPTY;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // FSM output logic: next values of the registered result outputs.
  always_comb begin
    value_next_s     = value_r;
    blank_next_s     = blank_r;
    valid_next_s     = valid_r;
    changed_next_s   = 1'b0;
    seg_error_next_s = seg_error_r;
    if (accept_s) begin
      value_next_s   = new_value_s;
      blank_next_s   = new_blank_s;
      valid_next_s   = 1'b1;
      changed_next_s = ~valid_r | ({new_blank_s, new_value_s} != {blank_r, value_r});
    end else begin
      changed_next_s = 1'b0;
    end
    if (illegal_tick_s) begin
      seg_error_next_s = 1'b1;
    end else if (clear_error) begin
      seg_error_next_s = 1'b0;
    end else begin
      seg_error_next_s = seg_error_r;
    end
  end

  // Registered result outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      value_r     <= 8'h00;
      blank_r     <= 2'b00;
      valid_r     <= 1'b0;
      changed_r   <= 1'b0;
      seg_error_r <= 1'b0;
    end else begin
      value_r     <= value_next_s;
      blank_r     <= blank_next_s;
      valid_r     <= valid_next_s;
      changed_r   <= changed_next_s;
      seg_error_r <= seg_error_next_s;
    end
  end

  assign value     = value_r;
  assign blank     = blank_r;
  assign valid     = valid_r;
  assign changed   = changed_r;
  assign seg_error = seg_error_r;
  assign state     = state_r;

endmodule
